// File: rtl/heichips25_uart_bridge.sv
// UART receive bridge for a tiny-wrapper slot: an 8N1 rx pin feeds a small FIFO that is popped over the bidir pins.
// Define HEICHIPS25_UART_PARITY_EN to receive 8E1 frames instead of 8N1.
module heichips25_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TICK_W = $clog2(CLKS_PER_BIT);

  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef HEICHIPS25_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t state;

  logic              rx_meta, rx_sync, rx_prev;
  logic              pop_meta, pop_sync, pop_prev;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              frame_err;
  logic              overrun;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic clear;
  logic rx_fall;
  logic stop_tick;
  logic parity_ok;
  logic frame_ok;
  logic push_req;
  logic valid;
  logic full;
  logic do_pop;
  logic do_push;
  logic rx_busy;
  logic [3:0] count_ext;
  logic [2:0] fill;
  logic unused_pins;

  // Both pad inputs are asynchronous to clk; rx idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      pop_meta <= 1'b0;
      pop_sync <= 1'b0;
      pop_prev <= 1'b0;
    end else begin
      rx_meta  <= ui_in[0];
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      pop_meta <= uio_in[1];
      pop_sync <= pop_meta;
      pop_prev <= pop_sync;
    end
  end

  assign clear     = ui_in[1];
  assign rx_fall   = rx_prev & ~rx_sync;
  assign stop_tick = (state == ST_STOP) && (tick == FULL_TICK);

`ifdef HEICHIPS25_UART_PARITY_EN
  logic par_bit;
  assign parity_ok = ~(^{shift, par_bit});
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = rx_sync & parity_ok;
  assign push_req = ena & stop_tick & frame_ok;
  assign valid    = (count != '0);
  assign full     = (count == DEPTH_CNT);
  assign do_pop   = ena & pop_sync & ~pop_prev & valid;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push  = push_req & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tick      <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
`ifdef HEICHIPS25_UART_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (clear) begin
      state     <= ST_IDLE;
      tick      <= '0;
      frame_err <= 1'b0;
    end else if (!ena) begin
      state <= ST_IDLE;
      tick  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state <= ST_START;
            tick  <= '0;
          end
        end
        // A start bit that is high again at mid-bit was a glitch.
        ST_START: begin
          if (tick == HALF_TICK) begin
            tick    <= '0;
            bit_idx <= 3'd0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick == FULL_TICK) begin
            tick    <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef HEICHIPS25_UART_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef HEICHIPS25_UART_PARITY_EN
        ST_PARITY: begin
          if (tick == FULL_TICK) begin
            tick    <= '0;
            par_bit <= rx_sync;
            state   <= ST_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick == FULL_TICK) begin
            tick  <= '0;
            state <= ST_IDLE;
            if (!frame_ok) frame_err <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push_req && full && !do_pop) overrun <= 1'b1;
    end
  end

  assign rx_busy   = (state != ST_IDLE);
  assign count_ext = 4'(count);
  assign fill      = (count_ext > 4'd7) ? 3'd7 : count_ext[2:0];

  assign uo_out  = valid ? mem[rd_ptr] : 8'h00;
  assign uio_out = {fill, rx_busy, frame_err, overrun, 1'b0, valid};
  assign uio_oe  = 8'hFD;

  assign unused_pins = &{1'b0, ui_in[7:2], uio_in[7:2], uio_in[0]};

endmodule

// File: tb/tb_heichips25_uart_bridge.sv
// Directed bench for heichips25_uart_bridge at CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_heichips25_uart_bridge;

  localparam int CPB = 16;
`ifdef HEICHIPS25_UART_PARITY_EN
  localparam int LAT = 155 + CPB;
  logic bad_par = 1'b0;
`else
  localparam int LAT = 155;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  heichips25_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one complete frame on the rx pad, LSB first, then four idle clocks.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    ui_in[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[0] = data[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef HEICHIPS25_UART_PARITY_EN
    ui_in[0] = (^data) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    ui_in[0] = stop_bit;
    repeat (CPB) @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_once();
    uio_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    uio_in[1] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    ui_in[1] = 1'b1;
    @(negedge clk);
    ui_in[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      @(negedge clk);
      checks++; if (uo_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_uo_out: got %h expected 00", uo_out); end
      checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_uio_out: got %h expected 00", uio_out); end
      checks++; if (uio_oe !== 8'hFD) begin errors++; $display("[TB] FAIL reset_uio_oe: got %h expected fd", uio_oe); end
    end
    ui_in  = 8'h01;
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_uo_out: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_uio_out: got %h expected 00", uio_out); end
    checks++; if (uio_oe !== 8'hFD) begin errors++; $display("[TB] FAIL post_reset_uio_oe: got %h expected fd", uio_oe); end
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        checks++; if (uio_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL early_valid: got %b expected 0", uio_out[0]); end
        @(negedge clk);
        checks++; if (uio_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid: got %b expected 1", uio_out[0]); end
        checks++; if (uo_out !== 8'hA5) begin errors++; $display("[TB] FAIL latency_data: got %h expected a5", uo_out); end
        checks++; if (uio_out[7:5] !== 3'd1) begin errors++; $display("[TB] FAIL latency_count: got %0d expected 1", uio_out[7:5]); end
      end
    join
    checks++; if (uio_out[4] !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got %b expected 0", uio_out[4]); end
    uio_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL single_pop_flags: got %h expected 00", uio_out); end
    checks++; if (uo_out !== 8'h00) begin errors++; $display("[TB] FAIL single_pop_data: got %h expected 00", uo_out); end
    uio_in[1] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [7:0] exp_byte;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    checks++; if (uio_out[7:5] !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", uio_out[7:5]); end
    checks++; if (uio_out[2] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", uio_out[2]); end
    for (int b = 1; b <= 4; b++) begin
      exp_byte = 8'(b);
      checks++; if (uo_out !== exp_byte) begin errors++; $display("[TB] FAIL ovf_order: got %h expected %h", uo_out, exp_byte); end
      pop_once();
    end
    checks++; if (uio_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got %b expected 0", uio_out[0]); end
    checks++; if (uio_out[2] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", uio_out[2]); end
    pop_once();
    checks++; if (uio_out !== 8'h04) begin errors++; $display("[TB] FAIL pop_empty: got %h expected 04", uio_out); end
    pulse_clear();
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 00", uio_out); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_byte;
    for (int b = 1; b <= 4; b++) send_frame(8'(b * 8'h11), 1'b1);
    checks++; if (uio_out[7:5] !== 3'd4) begin errors++; $display("[TB] FAIL fpp_fill: got %0d expected 4", uio_out[7:5]); end
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (LAT - 3) @(negedge clk);
        uio_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        uio_in[1] = 1'b0;
      end
    join
    checks++; if (uio_out[7:5] !== 3'd4) begin errors++; $display("[TB] FAIL fpp_count: got %0d expected 4", uio_out[7:5]); end
    checks++; if (uio_out[2] !== 1'b0) begin errors++; $display("[TB] FAIL fpp_overrun: got %b expected 0", uio_out[2]); end
    for (int b = 2; b <= 5; b++) begin
      exp_byte = 8'(b * 8'h11);
      checks++; if (uo_out !== exp_byte) begin errors++; $display("[TB] FAIL fpp_order: got %h expected %h", uo_out, exp_byte); end
      pop_once();
    end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL fpp_empty: got %h expected 00", uio_out); end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    checks++; if (uio_out[3] !== 1'b1) begin errors++; $display("[TB] FAIL frame_err_set: got %b expected 1", uio_out[3]); end
    checks++; if (uio_out[7:5] !== 3'd0) begin errors++; $display("[TB] FAIL frame_no_push: got %0d expected 0", uio_out[7:5]); end
    send_frame(8'h3C, 1'b1);
    checks++; if (uo_out !== 8'h3C) begin errors++; $display("[TB] FAIL frame_good_data: got %h expected 3c", uo_out); end
    checks++; if (uio_out !== 8'h29) begin errors++; $display("[TB] FAIL frame_good_flags: got %h expected 29", uio_out); end
    pulse_clear();
    checks++; if (uio_out[3:2] !== 2'b00) begin errors++; $display("[TB] FAIL frame_clear_flags: got %b expected 00", uio_out[3:2]); end
    checks++; if (uio_out[7:5] !== 3'd0) begin errors++; $display("[TB] FAIL frame_clear_fifo: got %0d expected 0", uio_out[7:5]); end
  endtask

  task automatic test_glitch();
    ui_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    ui_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (uio_out[4] !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 1", uio_out[4]); end
    repeat (14) @(negedge clk);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL glitch_reject: got %h expected 00", uio_out); end
  endtask

  task automatic test_ena();
    send_frame(8'h21, 1'b1);
    ena = 1'b0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (40) @(negedge clk);
        checks++; if (uio_out[4] !== 1'b0) begin errors++; $display("[TB] FAIL ena_busy: got %b expected 0", uio_out[4]); end
      end
    join
    checks++; if (uo_out !== 8'h21) begin errors++; $display("[TB] FAIL ena_keep_data: got %h expected 21", uo_out); end
    checks++; if (uio_out !== 8'h21) begin errors++; $display("[TB] FAIL ena_keep_flags: got %h expected 21", uio_out); end
    pop_once();
    checks++; if (uo_out !== 8'h21) begin errors++; $display("[TB] FAIL ena_pop_ignored: got %h expected 21", uo_out); end
    ena = 1'b1;
    pop_once();
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL ena_pop: got %h expected 00", uio_out); end
    fork
      send_frame(8'h66, 1'b1);
      begin
        repeat (50) @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (uio_out[4] !== 1'b0) begin errors++; $display("[TB] FAIL ena_abandon: got %b expected 0", uio_out[4]); end
      end
    join
    ena = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL ena_abandon_flags: got %h expected 00", uio_out); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h42, 1'b1);
    checks++; if (uo_out !== 8'h42) begin errors++; $display("[TB] FAIL rmf_stored: got %h expected 42", uo_out); end
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL rmf_flags: got %h expected 00", uio_out); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("[TB] FAIL rmf_data: got %h expected 00", uo_out); end
      end
    join
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 1'b1);
    checks++; if (uo_out !== 8'hC3) begin errors++; $display("[TB] FAIL rmf_recover: got %h expected c3", uo_out); end
    pop_once();
  endtask

`ifdef HEICHIPS25_UART_PARITY_EN
  task automatic test_parity();
    bad_par = 1'b0;
    send_frame(8'h0F, 1'b1);
    checks++; if (uo_out !== 8'h0F) begin errors++; $display("[TB] FAIL parity_good: got %h expected 0f", uo_out); end
    checks++; if (uio_out !== 8'h21) begin errors++; $display("[TB] FAIL parity_good_flags: got %h expected 21", uio_out); end
    bad_par = 1'b1;
    send_frame(8'h0F, 1'b1);
    bad_par = 1'b0;
    checks++; if (uio_out !== 8'h29) begin errors++; $display("[TB] FAIL parity_bad: got %h expected 29", uio_out); end
    pulse_clear();
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h01;
    uio_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_framing();
    test_glitch();
    test_ena();
    test_reset_mid_frame();
`ifdef HEICHIPS25_UART_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/heichips25_uart_bridge.md
Name: heichips25_uart_bridge

Overview:
- Tiny-slot front-end that receives 8N1 UART bytes on a pad pin, buffers them in a small FIFO, and presents them on uo_out with a pop handshake on the bidirectional pins.
- Sits in one project slot of heichips25_tiny_wrapper, with the same pin interface as the other projects.
- Lets off-chip hosts stream operand/config bytes without a parallel bus.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; minimum 4, even values only.
FIFO_DEPTH, 4, FIFO entries; power of two, 2..8.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset; all state cleared while low
ena  input  1  slot enable
ui_in  input  8  [0] rx line (idle high); [1] synchronous clear; [7:2] unused
uio_in  input  8  [1] pop request (off-chip level); other bits ignored
uo_out  output  8  FIFO head byte; 8'h00 when empty
uio_out  output  8  [0] valid, [1] 0, [2] overrun (sticky), [3] frame_err (sticky), [4] rx_busy, [7:5] fill count (saturates at 7)
uio_oe  output  8  constant 8'b1111_1101

Behaviour:
- Reset: uo_out=0, uio_out=0, FIFO empty, FSM=IDLE, all flags 0. uio_oe=8'hFD always, including during reset.
- Synchronisation: ui_in[0] and uio_in[1] each pass a 2-FF synchroniser. Reset value is 1 for rx and 0 for pop.
- Pop:
  - Rising edge on synchronised pop while valid=1 advances the head. uo_out and count update on the next edge.
  - Pop while empty is ignored.
- RX FSM, bit counter 0..CLKS_PER_BIT-1:
  - IDLE: falling edge on synchronised rx (previous 1, now 0) -> START, counter cleared.
  - START: at counter=CLKS_PER_BIT/2-1, sample. rx=0 -> DATA. rx=1 -> IDLE (glitch rejected, nothing flagged).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first into a shift register, then -> STOP.
  - STOP: sample once.
    - rx=1 and FIFO not full: push byte.
    - rx=1 and FIFO full: byte dropped, overrun=1.
    - rx=0: byte discarded, frame_err=1.
    - All cases -> IDLE.
  - rx_busy = (state != IDLE).
- Latency: byte visible on uo_out/valid one cycle after the stop mid-sample. With CLKS_PER_BIT=16 that is 155 clk after the pad start edge (2 sync + 1 edge-detect + 7 + 144 + 1).
- Simultaneous push and pop:
  - When full: both occur, no overrun, count unchanged.
  - When empty: pop ignored, push occurs.
- Pointers wrap modulo FIFO_DEPTH. Count is width log2(FIFO_DEPTH)+1 and is zero-extended/saturated onto [7:5].
- Clear (ui_in[1]=1, sampled raw, synchronous):
  - Empties the FIFO, clears overrun and frame_err, forces FSM to IDLE.
  - Has priority over push and pop in the same cycle.
- ena=0:
  - FSM held in IDLE, pops ignored; FIFO contents and flags retained; outputs still driven.
  - Frame in flight is abandoned, no flag set.
- Reset mid-frame: immediate return to reset state; partial byte is lost.

Optional Feature:
Macro HEICHIPS25_UART_PARITY_EN.
- Defined: frame is 8E1. A PARITY state between DATA and STOP samples one extra bit. If the parity is not even over data plus parity, at STOP the byte is discarded and frame_err=1 regardless of the stop bit. Latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state exists.

Test Plan:
1. Reset check: hold rst_n=0 with random ui_in -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'hFD; release -> unchanged until rx activity.
2. Single byte 0xA5 (CLKS_PER_BIT=16) -> 155 clk after start edge: valid=1, uo_out=8'hA5, count=1. After pop edge plus 4 clk -> valid=0, uo_out=8'h00.
3. Overflow: send 0x01..0x05 without popping -> count=4, overrun=1, uo_out=8'h01. Four pops -> 01,02,03,04 in order, then valid=0. overrun stays 1 until ui_in[1] pulsed.
4. Framing: send 0x3C with stop bit driven 0 -> frame_err=1, count=0. Send 0x3C correctly -> accepted. One-cycle clear -> uio_out[3:2]=2'b00.
5. Glitch and ena: 4-clk low pulse on rx -> rx_busy returns 0, no push, no flags. With ena=0, full frame 0x77 -> no push, count unchanged.
6. Macro defined: 0x0F with parity 0 -> accepted. 0x0F with parity 1 -> frame_err=1, no push.
